// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL channel structs and opcodes (no integrity fields).
package tlul_pkg;

    localparam logic [2:0] OpPutFull = 3'h0;
    localparam logic [2:0] OpPutPartial = 3'h1;
    localparam logic [2:0] OpGet = 3'h4;
    localparam logic [2:0] OpAccessAck = 3'h0;
    localparam logic [2:0] OpAccessAckData = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [0:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_mem_responder.sv
// tlul_mem_responder: TL-UL device responder running one word access at a time
// on a req/gnt/rvalid memory port.
module tlul_mem_responder
    import tlul_pkg::*;
#(
    parameter int          AddrWidth = 15,
    parameter logic [31:0] ErrRdata  = 32'hFFFF_FFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  tl_h2d_t              tl_i,
    output tl_d2h_t              tl_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q;
    logic [1:0]           size_q;
    logic [7:0]           src_q;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           mask_q;
    logic [31:0]          data_q, rdata_q;
    logic                 we_q, err_q;
    logic [3:0]           sel_be;
    logic [1:0]           align_mask;
    logic                 legal;
    logic                 unused_tl;

    assign unused_tl = ^tl_i.a_param;

    always_comb begin
        sel_be = tl_i.a_size == 2'd0 ? 4'b0001 << tl_i.a_address[1:0] :
                 tl_i.a_size == 2'd1 ? 4'b0011 << tl_i.a_address[1:0] : 4'b1111;
        align_mask = tl_i.a_size == 2'd0 ? 2'b00 : tl_i.a_size == 2'd1 ? 2'b01 : 2'b11;
        legal = (tl_i.a_opcode == OpGet || tl_i.a_opcode == OpPutFull ||
                 tl_i.a_opcode == OpPutPartial) &&
                tl_i.a_size != 2'd3 &&
                (tl_i.a_address[1:0] & align_mask) == 2'b00 &&
                (tl_i.a_mask & ~sel_be) == 4'b0000 &&
                (tl_i.a_opcode != OpPutFull || tl_i.a_mask == sel_be) &&
                tl_i.a_address[31:AddrWidth+2] == '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tl_i.a_valid) state_d = legal ? REQ : RESP;
            REQ:     if (mem_gnt_i) state_d = WAIT;
            WAIT:    if (mem_rvalid_i) state_d = RESP;
            default: if (tl_i.d_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q    <= '0;
            size_q  <= '0;
            src_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (state_q == IDLE && tl_i.a_valid) begin
            op_q   <= tl_i.a_opcode;
            size_q <= tl_i.a_size;
            src_q  <= tl_i.a_source;
            addr_q <= tl_i.a_address[AddrWidth+1:2];
            mask_q <= tl_i.a_mask;
            data_q <= tl_i.a_data;
            we_q   <= tl_i.a_opcode != OpGet;
            err_q  <= ~legal;
        end else if (state_q == WAIT && mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            err_q   <= mem_err_i;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = state_q == IDLE;
        tl_o.d_valid  = state_q == RESP;
        tl_o.d_opcode = op_q == OpGet ? OpAccessAckData : OpAccessAck;
        tl_o.d_size   = size_q;
        tl_o.d_source = src_q;
        tl_o.d_error  = err_q;
        tl_o.d_data   = op_q == OpGet ? (err_q ? ErrRdata : rdata_q) : '0;
        mem_req_o     = state_q == REQ;
        mem_we_o      = we_q;
        mem_addr_o    = addr_q;
        mem_wdata_o   = data_q;
        mem_be_o      = mask_q;
    end

endmodule

// File: tb/tb_tlul_mem_responder.sv
// tb_tlul_mem_responder: directed checks of the TL-UL memory responder against
// hand-computed responses and latencies.
module tb_tlul_mem_responder;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
    logic [14:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [256];
    int          lat;
    logic        saw_req, req_stable, d_stable, m_we;
    logic [14:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    tl_d2h_t     d_snap;

    tlul_mem_responder dut (
        .clk_i(clk), .rst_i(rst_i), .tl_i(tl_i), .tl_o(tl_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one A/D transaction; gnt_dly cycles of stall in REQ, rdy_dly cycles of D backpressure
    task automatic run(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                       input int gnt_dly, input int rdy_dly, input logic merr);
        int          gnt_cnt;
        logic        pend;
        logic [31:0] rd;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = sz;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
        chk("a_ready_pre", tl_o.a_ready, 1);
        @(posedge clk); #1;
        tl_i.a_valid = 1'b0;
        lat = 0; saw_req = 0; req_stable = 1; gnt_cnt = 0; pend = 0; rd = '0;
        while (!tl_o.d_valid && lat < 50) begin
            mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
            if (pend) begin
                mem_rvalid_i = 1; mem_err_i = merr; mem_rdata_i = rd; pend = 0;
            end
            if (mem_req_o) begin
                if (!saw_req) begin
                    saw_req = 1; m_we = mem_we_o; m_addr = mem_addr_o; m_be = mem_be_o; m_wdata = mem_wdata_o;
                end else if ({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== {m_we, m_addr, m_be, m_wdata})
                    req_stable = 0;
                if (gnt_cnt == gnt_dly) begin
                    mem_gnt_i = 1; pend = 1; rd = mem[mem_addr_o[7:0]];
                    if (mem_we_o)
                        for (int b = 0; b < 4; b++)
                            if (mem_be_o[b]) mem[mem_addr_o[7:0]][8*b+:8] = mem_wdata_o[8*b+:8];
                end else gnt_cnt++;
            end
            @(posedge clk); #1;
            lat++;
        end
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
        chk("d_valid_arrives", tl_o.d_valid, 1);
        d_snap = tl_o; d_stable = 1;
        repeat (rdy_dly) begin
            @(posedge clk); #1;
            if (tl_o !== d_snap) d_stable = 0;
        end
        tl_i.d_ready = 1'b1;
        @(posedge clk); #1;
        tl_i.d_ready = 1'b0;
        chk("a_ready_post", tl_o.a_ready, 1);
        chk("d_valid_drop", tl_o.d_valid, 0);
    endtask

    task automatic ck_d(input string t, input int e_lat, input logic e_req, input logic [2:0] e_op,
                        input logic e_err, input logic [31:0] e_data, input logic [7:0] e_src,
                        input logic [1:0] e_sz);
        chk({t, ":lat"}, lat, e_lat);
        chk({t, ":mem_req"}, saw_req, e_req);
        chk({t, ":d_opcode"}, d_snap.d_opcode, e_op);
        chk({t, ":d_error"}, d_snap.d_error, e_err);
        chk({t, ":d_data"}, d_snap.d_data, e_data);
        chk({t, ":d_source"}, d_snap.d_source, e_src);
        chk({t, ":d_size"}, d_snap.d_size, e_sz);
        chk({t, ":d_zero"}, {d_snap.d_param, d_snap.d_sink, d_snap.d_user}, 0);
    endtask

    initial begin
        tl_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:a_ready", tl_o.a_ready, 1);
        chk("rst:d_valid", tl_o.d_valid, 0);
        chk("rst:d_fields", {tl_o.d_opcode, tl_o.d_param, tl_o.d_size, tl_o.d_source, tl_o.d_sink,
                             tl_o.d_user, tl_o.d_error}, 0);
        chk("rst:d_data", tl_o.d_data, 0);
        chk("rst:mem_ctl", {mem_req_o, mem_we_o}, 0);
        chk("rst:mem_addr_be", {mem_addr_o, mem_be_o}, 0);
        chk("rst:mem_wdata", mem_wdata_o, 0);
        rst_i = 0;

        run(OpPutFull, 2, 32'h100, 4'hF, 32'hDEAD_BEEF, 8'd5, 0, 0, 0);
        ck_d("put", 2, 1, OpAccessAck, 0, 0, 8'd5, 2);
        chk("put:we", m_we, 1);
        chk("put:addr", m_addr, 15'h40);
        chk("put:be", m_be, 4'hF);
        chk("put:wdata", m_wdata, 32'hDEAD_BEEF);

        run(OpGet, 2, 32'h100, 4'hF, 0, 8'd7, 0, 0, 0);
        ck_d("get", 2, 1, OpAccessAckData, 0, 32'hDEAD_BEEF, 8'd7, 2);
        chk("get:we", m_we, 0);

        run(OpPutPartial, 0, 32'h103, 4'h8, 32'hAA00_0000, 8'd9, 0, 0, 0);
        ck_d("pp", 2, 1, OpAccessAck, 0, 0, 8'd9, 0);
        chk("pp:be", m_be, 4'h8);
        chk("pp:addr", m_addr, 15'h40);

        run(OpGet, 2, 32'h100, 4'hF, 0, 8'd3, 0, 0, 0);
        ck_d("get2", 2, 1, OpAccessAckData, 0, 32'hAAAD_BEEF, 8'd3, 2);

        run(OpGet, 2, 32'h102, 4'hF, 0, 8'd1, 0, 0, 0);
        ck_d("ill_align", 0, 0, OpAccessAckData, 1, 32'hFFFF_FFFF, 8'd1, 2);

        run(3'd2, 2, 32'h100, 4'hF, 0, 8'd2, 0, 0, 0);
        chk("ill_op:lat", lat, 0);
        chk("ill_op:mem_req", saw_req, 0);
        chk("ill_op:d_error", d_snap.d_error, 1);

        run(OpGet, 2, 32'h0002_0000, 4'hF, 0, 8'd4, 0, 0, 0);
        ck_d("ill_range", 0, 0, OpAccessAckData, 1, 32'hFFFF_FFFF, 8'd4, 2);

        run(OpPutFull, 2, 32'h100, 4'h7, 32'h1234_5678, 8'd6, 0, 0, 0);
        ck_d("ill_mask", 0, 0, OpAccessAck, 1, 0, 8'd6, 2);

        run(OpGet, 2, 32'h100, 4'hF, 0, 8'd8, 5, 0, 1);
        ck_d("stall", 7, 1, OpAccessAckData, 1, 32'hFFFF_FFFF, 8'd8, 2);
        chk("stall:req_stable", req_stable, 1);

        run(OpGet, 2, 32'h100, 4'hF, 0, 8'd9, 0, 4, 0);
        ck_d("bp", 2, 1, OpAccessAckData, 0, 32'hAAAD_BEEF, 8'd9, 2);
        chk("bp:d_stable", d_stable, 1);

        tl_i.a_valid = 1; tl_i.a_opcode = OpGet; tl_i.a_size = 2;
        tl_i.a_address = 32'h100; tl_i.a_mask = 4'hF; tl_i.a_source = 8'd11;
        @(posedge clk); #1;
        tl_i.a_valid = 0;
        chk("rw:req", mem_req_o, 1);
        mem_gnt_i = 1;
        @(posedge clk); #1;
        mem_gnt_i = 0;
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
        mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
        @(posedge clk); #1;
        mem_rvalid_i = 0; mem_rdata_i = '0;
        chk("rw:d_valid", tl_o.d_valid, 0);
        chk("rw:a_ready", tl_o.a_ready, 1);
        @(posedge clk); #1;
        chk("rw:d_valid2", tl_o.d_valid, 0);
        chk("rw:mem_req", mem_req_o, 0);

        run(OpGet, 2, 32'h100, 4'hF, 0, 8'd10, 0, 0, 0);
        ck_d("post_rst", 2, 1, OpAccessAckData, 0, 32'hAAAD_BEEF, 8'd10, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
